// File: rtl/bwt_block_engine.sv
// bwt_block_engine: forward Burrows-Wheeler transform over a runtime-length block,
// ranking every cyclic rotation with a sequential symbol-by-symbol comparator.
module bwt_block_engine #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int LW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic [LW-1:0] primary_idx,
    output logic [LW:0]   blk_len,
    output logic          busy
);
    typedef enum logic [1:0] {LOAD, RANK, EMIT} state_t;
    state_t state, state_nx;
    logic [W-1:0] s [N];
    logic [W-1:0] bwt [N];
    logic [LW:0] count, len;
    logic [LW-1:0] i, j, k, pa, pb, rank, rank_nx, e, last, prev;
    logic hs_in, blk_end, same, eq_sym, k_last, end_cmp, rank_inc, i_done, j_last;

    assign last     = LW'(len - 1'b1);
    assign hs_in    = in_valid && in_ready;
    assign blk_end  = hs_in && (in_last || count == (LW+1)'(N - 1));
    assign same     = (i == j);
    assign eq_sym   = (s[pa] == s[pb]);
    assign k_last   = (k == last);
    assign end_cmp  = same || !eq_sym || k_last;
    // Equal rotations are ordered by index so the ranks always form a permutation
    assign rank_inc = !same && ((s[pb] < s[pa]) || (eq_sym && k_last && (j < i)));
    assign rank_nx  = rank + LW'(rank_inc);
    assign prev     = (i == '0) ? last : i - 1'b1;
    assign j_last   = (j == last);
    assign i_done   = (state == RANK) && end_cmp && j_last;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign out_data  = out_valid ? bwt[e] : '0;
    assign out_last  = out_valid && (e == last);
    assign busy      = !(state == LOAD && count == '0);

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= LOAD;
        else      state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = blk_end ? RANK : LOAD;
            RANK:    state_nx = (i_done && i == last) ? EMIT : RANK;
            EMIT:    state_nx = (out_ready && e == last) ? LOAD : EMIT;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hs_in) s[count[LW-1:0]] <= in_data;
        if (i_done) bwt[rank_nx] <= s[prev];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            len         <= '0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            pa          <= '0;
            pb          <= '0;
            rank        <= '0;
            e           <= '0;
            primary_idx <= '0;
            blk_len     <= '0;
        end else begin
            case (state)
                LOAD: if (hs_in) begin
                    count <= count + 1'b1;
                    if (blk_end) begin
                        len  <= count + 1'b1;
                        i    <= '0;
                        j    <= '0;
                        k    <= '0;
                        pa   <= '0;
                        pb   <= '0;
                        rank <= '0;
                    end
                end
                RANK: if (end_cmp) begin
                    k <= '0;
                    if (j_last) begin
                        rank <= '0;
                        i    <= i + 1'b1;
                        j    <= '0;
                        pa   <= i + 1'b1;
                        pb   <= '0;
                        if (i == '0) primary_idx <= rank_nx;
                        if (i == last) begin
                            blk_len <= len;
                            e       <= '0;
                        end
                    end else begin
                        rank <= rank_nx;
                        j    <= j + 1'b1;
                        pa   <= i;
                        pb   <= j + 1'b1;
                    end
                end else begin
                    k  <= k + 1'b1;
                    pa <= (pa == last) ? '0 : pa + 1'b1;
                    pb <= (pb == last) ? '0 : pb + 1'b1;
                end
                EMIT: if (out_ready) begin
                    if (e == last) count <= '0;
                    else           e <= e + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
